sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
Serial-in, parallel-out frame receiver that sits directly downstream of the siso shift register and consumes its serial_out bit stream. It hunts for a fixed sync pattern and assembles the following WIDTH data bits, MSB first, into a word. It then checks a trailing even-parity bit and presents the word with a one-cycle valid pulse. A frame counter and error pulse support link monitoring.

Parameters:
- WIDTH, 8, data bits per frame (>=2)
- SYNC_LEN, 4, sync pattern length in bits (>=2)
- SYNC_PAT, 4'b1011, sync pattern, MSB received first

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- serial_in  input  1  serial bit stream from upstream siso serial_out
- bit_en  input  1  bit qualifier; serial_in is sampled only on clk edges where bit_en=1
- data_out  output  WIDTH  last good received word, held until the next good frame
- data_valid  output  1  one-cycle pulse when data_out is updated
- parity_err  output  1  one-cycle pulse when a frame fails parity
- busy  output  1  high while in DATA or PARITY
- frame_cnt  output  8  count of good frames, wraps 255->0

Behaviour:
- Reset is synchronous only: on a clk edge with rst_n=0, state=HUNT and every register clears. data_out=0, data_valid=0, parity_err=0, busy=0, frame_cnt=0, shift registers=0, counters=0. Reset mid-frame discards the partial frame.
- All outputs are registered.
- When bit_en=0, state, shift registers and counters hold. data_valid and parity_err still return to 0.
- States: HUNT, DATA, PARITY.
- HUNT, on bit_en:
  - sync_sr <= {sync_sr[SYNC_LEN-2:0], serial_in}; hunt_cnt increments, saturating at SYNC_LEN.
  - Match condition: the updated window equals SYNC_PAT and hunt_cnt+1 >= SYNC_LEN. A stale zero-filled window must never match.
  - On match: go to DATA with bit_cnt=0 and hunt_cnt=0. The search is sliding, so overlapping preambles match at the earliest valid position.
- DATA, on bit_en:
  - data_sr <= {data_sr[WIDTH-2:0], serial_in}; bit_cnt increments.
  - After the WIDTH-th bit, go to PARITY.
- PARITY, on bit_en: parity_bad = (^data_sr) ^ serial_in, i.e. even parity over data plus parity bit.
  - If parity_bad=0: data_out <= data_sr, data_valid <= 1, frame_cnt <= frame_cnt+1 (mod 256).
  - If parity_bad=1: parity_err <= 1; data_out and frame_cnt are unchanged.
  - Either way, go to HUNT with sync_sr cleared and hunt_cnt=0. The next frame needs a full fresh sync pattern.
- Latency: data_valid and parity_err rise on the same clk edge that samples the parity bit, are visible for exactly one cycle, and deassert on the next edge. data_valid and parity_err are never high together.
- busy=1 from the edge that enters DATA until the edge that leaves PARITY.
- Bits arriving in DATA or PARITY are never examined for sync.
- Back-to-back frames: the sync pattern may start on the first bit_en after PARITY.

Test Plan:
- Good frame: after reset, bit_en=1 continuously, stream 1,0,1,1, then 0,0,1,1,1,1,0,0, then parity 0. Expect data_out=8'h3C, data_valid high exactly 1 cycle on the parity-sample edge, frame_cnt=1, parity_err=0, and busy high for 9 cycles.
- Bad parity: same stream with parity 1. Expect parity_err pulse of 1 cycle, data_valid=0, data_out and frame_cnt unchanged, state back in HUNT.
- Sliding hunt: prefix 1,1,0,1,1 then 8'hA5 (1,0,1,0,0,1,0,1) and parity 0. Sync matches on the 5th bit, then expect data_out=8'hA5 and frame_cnt incremented. Separately, zeros only after reset must never match.
- bit_en gaps: the good 0x3C frame with bit_en=0 on alternate cycles and garbage on serial_in during those cycles. Expect the identical result (data_out=8'h3C, 1-cycle data_valid) and no state change on gated cycles.
- Reset mid-frame: assert rst_n=0 for 1 cycle after 4 data bits. Expect all outputs 0 and HUNT. A subsequent full 0x3C frame is received correctly.
- Counter wrap: 256 consecutive good frames. Expect frame_cnt to read 255 then 0, with a data_valid pulse for every frame.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Serial-in parallel-out frame receiver: hunts for a sync pattern, then captures
// WIDTH data bits MSB first, checks even parity and reports the frame.
module sipo_frame_rx #(
    parameter int                  WIDTH    = 8,
    parameter int                  SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int HW = $clog2(SYNC_LEN + 1);
    localparam int BW = $clog2(WIDTH);
    localparam logic [HW:0]   SYNC_LEN_W = (HW+1)'(SYNC_LEN);
    localparam logic [HW-1:0] HUNT_MAX   = HW'(SYNC_LEN);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t              r_state;
    logic [SYNC_LEN-1:0] r_sync_sr;
    logic [HW-1:0]       r_hunt_cnt;
    logic [WIDTH-1:0]    r_data_sr;
    logic [BW-1:0]       r_bit_cnt;
    logic [WIDTH-1:0]    r_data_out;
    logic                r_data_valid;
    logic                r_parity_err;
    logic                r_busy;
    logic [7:0]          r_frame_cnt;

    logic [SYNC_LEN-1:0] w_sync_next;
    logic [HW:0]         w_hunt_inc;
    logic [HW-1:0]       w_hunt_sat;
    logic                w_match;
    logic                w_parity_bad;

    function automatic logic f_xor_reduce(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Next sync window, saturating hunt count and match/parity decisions
    always_comb begin
        w_sync_next  = {r_sync_sr[SYNC_LEN-2:0], serial_in};
        w_hunt_inc   = {1'b0, r_hunt_cnt} + {{HW{1'b0}}, 1'b1};
        w_hunt_sat   = r_hunt_cnt;
        w_parity_bad = f_xor_reduce(r_data_sr) ^ serial_in;
        if (r_hunt_cnt == HUNT_MAX) begin
            w_hunt_sat = r_hunt_cnt;
        end else begin
            w_hunt_sat = w_hunt_inc[HW-1:0];
        end
        // Require SYNC_LEN real bits so a zero-filled window can never match
        if ((w_sync_next == SYNC_PAT) && (w_hunt_inc >= SYNC_LEN_W)) begin
            w_match = 1'b1;
        end else begin
            w_match = 1'b0;
        end
    end

    // Receiver FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_sync_sr    <= '0;
            r_hunt_cnt   <= '0;
            r_data_sr    <= '0;
            r_bit_cnt    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    ST_HUNT: begin
                        r_sync_sr <= w_sync_next;
                        if (w_match) begin
                            r_state    <= ST_DATA;
                            r_bit_cnt  <= '0;
                            r_hunt_cnt <= '0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_hunt_cnt <= w_hunt_sat;
                        end
                    end
                    ST_DATA: begin
                        r_data_sr <= {r_data_sr[WIDTH-2:0], serial_in};
                        r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        if (w_parity_bad) begin
                            r_parity_err <= 1'b1;
                        end else begin
                            r_data_out   <= r_data_sr;
                            r_data_valid <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 8'd1;
                        end
                        r_state    <= ST_HUNT;
                        r_sync_sr  <= '0;
                        r_hunt_cnt <= '0;
                        r_busy     <= 1'b0;
                    end
                    default: begin
                        r_state    <= ST_HUNT;
                        r_sync_sr  <= '0;
                        r_hunt_cnt <= '0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed, table-driven bench for sipo_frame_rx: each record is one clock with
// its inputs and the outputs expected just after that edge.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic       bit_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       busy;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       si;
        logic       v;
        logic       p;
        logic       b;
        logic [7:0] d;
        logic [7:0] c;
        string      tag;
    } vec_t;

    vec_t q[$];
    logic [7:0] exp_d;
    logic [7:0] exp_c;
    logic       exp_b;

    sipo_frame_rx #(.WIDTH(8), .SYNC_LEN(4), .SYNC_PAT(4'b1011)) dut (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_en(bit_en),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic push(input logic r, input logic en, input logic si,
                        input logic v, input logic p, input string tag);
        vec_t e;
        e.rst_n = r; e.en = en; e.si = si; e.v = v; e.p = p;
        e.b = exp_b; e.d = exp_d; e.c = exp_c; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic add_reset(input string tag);
        exp_d = 8'h00; exp_c = 8'd0; exp_b = 1'b0;
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tag);
    endtask

    // One enabled bit, optionally followed by a gated cycle carrying garbage
    task automatic add_bit(input logic si, input logic v, input logic p,
                           input bit gap, input string tag);
        push(1'b1, 1'b1, si, v, p, tag);
        if (gap) push(1'b1, 1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0, {tag, "_gap"});
    endtask

    // Prefix (ending exactly where sync is expected to match), data, parity
    task automatic add_frame(input logic [15:0] pre, input int npre, input logic [7:0] d,
                             input logic par, input bit gap, input string tag);
        logic good;
        for (int i = npre - 1; i >= 0; i--) begin
            exp_b = (i == 0);
            add_bit(pre[i], 1'b0, 1'b0, gap, {tag, "_sync"});
        end
        for (int i = 7; i >= 0; i--) add_bit(d[i], 1'b0, 1'b0, gap, {tag, "_data"});
        good  = ((^d) ^ par) == 1'b0;
        exp_b = 1'b0;
        if (good) begin
            exp_d = d;
            exp_c = exp_c + 8'd1;
        end
        add_bit(par, good, !good, gap, {tag, "_par"});
    endtask

    task automatic run_table();
        for (int i = 0; i < q.size(); i++) begin
            rst_n     = q[i].rst_n;
            bit_en    = q[i].en;
            serial_in = q[i].si;
            @(posedge clk);
            #1;
            n_checks++;
            if ({data_valid, parity_err, busy, data_out, frame_cnt} !==
                {q[i].v, q[i].p, q[i].b, q[i].d, q[i].c}) begin
                n_fail++;
                $display("FAIL %s[%0d]: got v=%b p=%b busy=%b d=%h cnt=%0d, want v=%b p=%b busy=%b d=%h cnt=%0d",
                         q[i].tag, i, data_valid, parity_err, busy, data_out, frame_cnt,
                         q[i].v, q[i].p, q[i].b, q[i].d, q[i].c);
            end
        end
        q.delete();
    endtask

    initial begin
        int vcount;
        rst_n = 1'b0; bit_en = 1'b0; serial_in = 1'b0;
        exp_d = 8'h00; exp_c = 8'd0; exp_b = 1'b0;

        add_reset("reset");
        add_frame(16'b1011, 4, 8'h3C, 1'b0, 1'b0, "good3c");
        add_frame(16'b1011, 4, 8'h3C, 1'b1, 1'b0, "badpar");
        add_frame(16'b11011, 5, 8'hA5, 1'b0, 1'b0, "slide");
        add_frame(16'b1011, 4, 8'h3C, 1'b0, 1'b1, "gaps");
        add_reset("reset2");
        for (int i = 0; i < 10; i++) add_bit(1'b0, 1'b0, 1'b0, 1'b0, "zeros");
        exp_b = 1'b0;
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, "pre1");
        add_bit(1'b0, 1'b0, 1'b0, 1'b0, "pre0");
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, "pre1b");
        exp_b = 1'b1;
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, "pre1c");
        for (int i = 0; i < 4; i++) add_bit(1'b0, 1'b0, 1'b0, 1'b0, "partial");
        add_reset("midreset");
        add_frame(16'b1011, 4, 8'h3C, 1'b0, 1'b0, "after_rst");
        run_table();

        // Counter wrap: 256 back-to-back good frames from a fresh reset
        add_reset("wrap_rst");
        for (int f = 0; f < 256; f++) add_frame(16'b1011, 4, 8'h3C, 1'b0, 1'b0, "wrap");
        vcount = 0;
        for (int i = 0; i < q.size(); i++) if (q[i].v) vcount++;
        run_table();

        n_checks++;
        if (frame_cnt !== 8'd0 || vcount != 256) begin
            n_fail++;
            $display("FAIL wrap_final: cnt=%0d pulses_planned=%0d, want cnt=0 pulses=256",
                     frame_cnt, vcount);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
